// File: rtl/kbd_pkg.sv
// Shared types and helpers for the matrix keypad scanner: FSM states,
// keypad geometry and the single-key column decoder.
package kbd_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} kbd_state_t;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  typedef struct packed {
    logic             hit;
    logic [COL_W-1:0] idx;
  } col_hit_t;

  // hit is set only when exactly one column is pulled low; idx is that column
  function automatic col_hit_t onehot0_low(input logic [COLS-1:0] col);
    col_hit_t    res;
    int unsigned lows;
    res  = '0;
    lows = 0;
    for (int unsigned i = 0; i < COLS; i++) begin
      if (!col[i]) begin
        lows++;
        res.idx = COL_W'(i);
      end
    end
    res.hit = (lows == 1);
    return res;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler producing a one-cycle enable every DIV clocks;
// used instead of a divided clock so all logic stays on clk.
module scan_tick_gen #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == CW'(DIV - 1));
  assign o_tick = w_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_keypad_scanner.sv
// 4x4 active-low keypad scanner: one-cold row drive, synchronized column
// sampling, per-key debounce and single press/release event reporting.
module matrix_keypad_scanner
  import kbd_pkg::*;
#(
  parameter int unsigned F_CLK          = 50000000,
  parameter int unsigned F_SCAN         = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [COLS-1:0]  col_in,
  output logic [ROWS-1:0]  row_out,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  output logic             key_held,
  output logic             key_release
);

  localparam int unsigned DIV   = F_CLK / F_SCAN;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic [COLS-1:0]  r_col_m;
  logic [COLS-1:0]  r_col_s;
  logic             w_tick;
  col_hit_t         w_col_hit;
  logic             w_all_high;

  kbd_state_t       r_state,       w_state_nxt;
  logic [ROW_W-1:0] r_row,         w_row_nxt;
  logic [ROW_W-1:0] w_row_adv;
  logic [KEY_W-1:0] r_cand,        w_cand_nxt;
  logic [CNT_W-1:0] r_deb_cnt,     w_deb_cnt_nxt;
  logic [CNT_W-1:0] w_deb_inc;
  logic             w_deb_done;
  logic             r_key_valid,   w_key_valid_nxt;
  logic [KEY_W-1:0] r_key_code,    w_key_code_nxt;
  logic             r_key_held,    w_key_held_nxt;
  logic             r_key_release, w_key_release_nxt;

  scan_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .o_tick(w_tick)
  );

  // Columns idle high, so the synchronizer resets to all-released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_m <= '1;
      r_col_s <= '1;
    end else begin
      r_col_m <= col_in;
      r_col_s <= r_col_m;
    end
  end

  assign w_col_hit  = onehot0_low(r_col_s);
  assign w_all_high = &r_col_s;
  assign w_row_adv  = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + 1'b1;
  assign w_deb_inc  = (r_deb_cnt == DEB_MAX) ? r_deb_cnt : r_deb_cnt + 1'b1;
  assign w_deb_done = (w_deb_inc == DEB_MAX);

  always_comb begin
    w_state_nxt       = r_state;
    w_row_nxt         = r_row;
    w_cand_nxt        = r_cand;
    w_deb_cnt_nxt     = r_deb_cnt;
    w_key_valid_nxt   = 1'b0;
    w_key_code_nxt    = r_key_code;
    w_key_held_nxt    = r_key_held;
    w_key_release_nxt = 1'b0;

    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_col_hit.hit) begin
            w_cand_nxt = {r_row, w_col_hit.idx};
            if (DEBOUNCE_SCANS <= 1) begin
              w_key_code_nxt  = {r_row, w_col_hit.idx};
              w_key_valid_nxt = 1'b1;
              w_key_held_nxt  = 1'b1;
              w_deb_cnt_nxt   = '0;
              w_state_nxt     = PRESSED;
            end else begin
              w_deb_cnt_nxt = CNT_W'(1);
              w_state_nxt   = DEBOUNCE;
            end
          end else begin
            w_row_nxt = w_row_adv;
          end
        end

        DEBOUNCE: begin
          if (w_col_hit.hit && (w_col_hit.idx == r_cand[COL_W-1:0])) begin
            if (w_deb_done) begin
              w_key_code_nxt  = r_cand;
              w_key_valid_nxt = 1'b1;
              w_key_held_nxt  = 1'b1;
              w_deb_cnt_nxt   = '0;
              w_state_nxt     = PRESSED;
            end else begin
              w_deb_cnt_nxt = w_deb_inc;
            end
          end else begin
            w_deb_cnt_nxt = '0;
            w_row_nxt     = w_row_adv;
            w_state_nxt   = SCAN;
          end
        end

        PRESSED: begin
          // Any low column, including bounce, restarts the release run.
          if (w_all_high) begin
            if (w_deb_done) begin
              w_key_held_nxt    = 1'b0;
              w_key_release_nxt = 1'b1;
              w_deb_cnt_nxt     = '0;
              w_row_nxt         = w_row_adv;
              w_state_nxt       = SCAN;
            end else begin
              w_deb_cnt_nxt = w_deb_inc;
            end
          end else begin
            w_deb_cnt_nxt = '0;
          end
        end

        default: begin
          w_deb_cnt_nxt = '0;
          w_state_nxt   = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= SCAN;
      r_row         <= '0;
      r_cand        <= '0;
      r_deb_cnt     <= '0;
      r_key_valid   <= 1'b0;
      r_key_code    <= '0;
      r_key_held    <= 1'b0;
      r_key_release <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_row         <= w_row_nxt;
      r_cand        <= w_cand_nxt;
      r_deb_cnt     <= w_deb_cnt_nxt;
      r_key_valid   <= w_key_valid_nxt;
      r_key_code    <= w_key_code_nxt;
      r_key_held    <= w_key_held_nxt;
      r_key_release <= w_key_release_nxt;
    end
  end

  assign row_out     = ~(ROWS'(1) << r_row);
  assign key_valid   = r_key_valid;
  assign key_code    = r_key_code;
  assign key_held    = r_key_held;
  assign key_release = r_key_release;

endmodule
